// File: rtl/mc_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_control_if : control/handshake bundle between controller and path |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mc_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [6:0]       func7;
  logic             br_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             md_done;
  logic             imem_req;
  logic             ir_write;
  logic             dmem_re;
  logic             dmem_we;
  logic [2:0]       RW_type;
  logic             reg_write;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             alu_src_a;
  logic             alu_src_b;
  logic [3:0]       ALUctl;
  logic [1:0]       wb_sel;
  logic             md_start;
  logic             retire;
  logic [CNT_W-1:0] instret;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state;

  modport master (
    input  opcode, func3, func7, br_taken, imem_ready, dmem_ready, md_done,
    output imem_req, ir_write, dmem_re, dmem_we, RW_type, reg_write, pc_write,
           pc_sel, alu_src_a, alu_src_b, ALUctl, wb_sel, md_start, retire,
           instret, trap, trap_cause, state
  );

  modport slave (
    output opcode, func3, func7, br_taken, imem_ready, dmem_ready, md_done,
    input  imem_req, ir_write, dmem_re, dmem_we, RW_type, reg_write, pc_write,
           pc_sel, alu_src_a, alu_src_b, ALUctl, wb_sel, md_start, retire,
           instret, trap, trap_cause, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_control : multi-cycle RV32I control FSM; MC_MULDIV_EN adds RV32M   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_control #(
  parameter int TMO_CYC = 16,
  parameter int CNT_W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  mc_control_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_R, K_I, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_MD
  } cls_t;

  // ALU codes follow the shared define.v table: {func7[5], func3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam int         WC_W    = $clog2(TMO_CYC + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TMO_CYC - 1);

  state_t           state_q, state_n;
  logic [WC_W-1:0]  wcnt_q, wcnt_n;
  logic [CNT_W-1:0] instret_q;
  logic             trap_q, trap_set;
  logic [1:0]       cause_q, cause_set;
  cls_t             cls_q, dec_cls;
  logic [3:0]       alu_q, dec_alu;
  logic [2:0]       f3_q;
  logic             dec_legal;

  always_comb begin
    dec_legal = 1'b0;
    dec_cls   = K_I;
    dec_alu   = ALU_ADD;
    case (bus.opcode)
      OP_R: begin
        dec_cls = K_R;
        dec_alu = {bus.func7[5], bus.func3};
        if (bus.func7 == 7'b0000000)
          dec_legal = 1'b1;
        else if (bus.func7 == 7'b0100000)
          dec_legal = (bus.func3 == 3'b000) || (bus.func3 == 3'b101);
`ifdef MC_MULDIV_EN
        else if (bus.func7 == 7'b0000001) begin
          dec_legal = 1'b1;
          dec_cls   = K_MD;
          dec_alu   = ALU_ADD;
        end
`endif
      end
      OP_I: begin
        dec_cls = K_I;
        dec_alu = {(bus.func3 == 3'b101) & bus.func7[5], bus.func3};
        case (bus.func3)
          3'b001:  dec_legal = (bus.func7 == 7'b0000000);
          3'b101:  dec_legal = (bus.func7 == 7'b0000000) || (bus.func7 == 7'b0100000);
          default: dec_legal = 1'b1;
        endcase
      end
      OP_BR: begin
        dec_cls   = K_BR;
        dec_legal = (bus.func3[2:1] != 2'b01);
        case (bus.func3[2:1])
          2'b10:   dec_alu = ALU_SLT;
          2'b11:   dec_alu = ALU_SLTU;
          default: dec_alu = ALU_SUB;
        endcase
      end
      OP_LD: begin
        dec_cls   = K_LD;
        dec_legal = (bus.func3 != 3'b011) && (bus.func3 != 3'b110) && (bus.func3 != 3'b111);
      end
      OP_ST: begin
        dec_cls   = K_ST;
        dec_legal = (bus.func3[2] == 1'b0) && (bus.func3[1:0] != 2'b11);
      end
      OP_LUI:   begin dec_cls = K_LUI;   dec_legal = 1'b1; end
      OP_AUIPC: begin dec_cls = K_AUIPC; dec_legal = 1'b1; end
      OP_JAL:   begin dec_cls = K_JAL;   dec_legal = 1'b1; end
      OP_JALR:  begin dec_cls = K_JALR;  dec_legal = 1'b1; end
      default:  dec_legal = 1'b0;
    endcase
  end

`ifdef MC_MULDIV_EN
  logic md_busy_q;
  always_ff @(posedge clk) begin
    if (rst) md_busy_q <= 1'b0;
    else     md_busy_q <= (state_q == S_EXEC) && (state_n == S_EXEC);
  end
`else
  logic unused_md_done;
  assign unused_md_done = bus.md_done;
`endif

  always_comb begin
    state_n       = state_q;
    wcnt_n        = wcnt_q;
    trap_set      = 1'b0;
    cause_set     = 2'd0;
    bus.imem_req  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.dmem_re   = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.RW_type   = 3'd0;
    bus.reg_write = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 2'd0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 1'b0;
    bus.ALUctl    = ALU_ADD;
    bus.wb_sel    = 2'd0;
    bus.md_start  = 1'b0;
    bus.retire    = 1'b0;
    // ALU steering stays stable for the whole execute/memory/writeback span
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      bus.ALUctl    = alu_q;
      bus.alu_src_a = (cls_q == K_AUIPC) || (cls_q == K_JAL);
      bus.alu_src_b = !((cls_q == K_R) || (cls_q == K_BR) || (cls_q == K_MD));
    end
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          wcnt_n       = '0;
          state_n      = S_DECODE;
        end else if (wcnt_q == WC_LAST) begin
          wcnt_n    = '0;
          trap_set  = 1'b1;
          cause_set = 2'd2;
          state_n   = S_TRAP;
        end else begin
          wcnt_n = wcnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_n = S_EXEC;
        end else begin
          trap_set  = 1'b1;
          cause_set = 2'd1;
          state_n   = S_TRAP;
        end
      end
      S_EXEC: begin
        case (cls_q)
          K_BR: begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = bus.br_taken ? 2'd1 : 2'd0;
            bus.retire   = 1'b1;
            state_n      = S_FETCH;
          end
          K_LD, K_ST: state_n = S_MEM;
`ifdef MC_MULDIV_EN
          K_MD: begin
            if (!md_busy_q)      bus.md_start = 1'b1;
            else if (bus.md_done) state_n     = S_WB;
          end
`endif
          default: state_n = S_WB;
        endcase
      end
      S_MEM: begin
        bus.dmem_re = (cls_q == K_LD);
        bus.dmem_we = (cls_q == K_ST);
        bus.RW_type = f3_q;
        if (bus.dmem_ready) begin
          wcnt_n = '0;
          if (cls_q == K_ST) begin
            bus.pc_write = 1'b1;
            bus.retire   = 1'b1;
            state_n      = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (wcnt_q == WC_LAST) begin
          wcnt_n    = '0;
          trap_set  = 1'b1;
          cause_set = 2'd3;
          state_n   = S_TRAP;
        end else begin
          wcnt_n = wcnt_q + 1'b1;
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
        bus.retire    = 1'b1;
        state_n       = S_FETCH;
        case (cls_q)
          K_LD:         bus.wb_sel = 2'd1;
          K_JAL:        begin bus.wb_sel = 2'd2; bus.pc_sel = 2'd1; end
          K_JALR:       begin bus.wb_sel = 2'd2; bus.pc_sel = 2'd2; end
          K_LUI:        bus.wb_sel = 2'd3;
          default:      bus.wb_sel = 2'd0;
        endcase
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wcnt_q    <= '0;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
      cls_q     <= K_I;
      alu_q     <= ALU_ADD;
      f3_q      <= 3'd0;
    end else begin
      state_q <= state_n;
      wcnt_q  <= wcnt_n;
      if (bus.retire) instret_q <= instret_q + 1'b1;
      if (trap_set) begin
        trap_q  <= 1'b1;
        cause_q <= cause_set;
      end
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        alu_q <= dec_alu;
        f3_q  <= bus.func3;
      end
    end
  end

  assign bus.instret    = instret_q;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.state      = state_q;
endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_control : directed vector table plus multi-cycle corner cases  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mc_control;
  localparam int TMO = 16;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_if #(.CNT_W(CW)) bus ();
  mc_control #(.TMO_CYC(TMO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       br;
    bit         ill;
    int         cyc;
    logic [3:0] alu;
    logic       sa;
    logic       sb;
    int         rw;
    logic [1:0] wb;
    logic [1:0] ps;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken   = 1'b0;
    bus.md_done    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ret_cyc = 0, trap_cyc = 0, rw_cnt = 0;
    logic [3:0] alu = 4'hF;
    logic sa = 1'bx, sb = 1'bx;
    logic [1:0] wb = 2'd0, ps = 2'd0;
    bit seen_exec = 1'b0;
    do_reset();
    bus.opcode = v.op; bus.func3 = v.f3; bus.func7 = v.f7; bus.br_taken = v.br;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (bus.state == 3'd2 && !seen_exec) begin
        seen_exec = 1'b1; alu = bus.ALUctl; sa = bus.alu_src_a; sb = bus.alu_src_b;
      end
      if (bus.reg_write) begin rw_cnt++; wb = bus.wb_sel; end
      if (bus.pc_write) ps = bus.pc_sel;
      if (bus.retire && ret_cyc == 0) ret_cyc = c;
      if (bus.state == 3'd5) begin trap_cyc = c; break; end
      if (ret_cyc != 0) break;
      @(negedge clk);
    end
    if (v.ill) begin
      chk($sformatf("v%0d.trap_cyc", idx), trap_cyc, v.cyc);
      chk($sformatf("v%0d.cause", idx), bus.trap_cause, 2'd1);
    end else begin
      chk($sformatf("v%0d.retire_cyc", idx), ret_cyc, v.cyc);
      chk($sformatf("v%0d.ALUctl", idx), alu, v.alu);
      chk($sformatf("v%0d.src_ab", idx), {sa, sb}, {v.sa, v.sb});
      chk($sformatf("v%0d.reg_writes", idx), rw_cnt, v.rw);
      if (v.rw != 0) chk($sformatf("v%0d.wb_sel", idx), wb, v.wb);
      chk($sformatf("v%0d.pc_sel", idx), ps, v.ps);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, tc, cnt;
    logic [1:0] wbs;
    logic [2:0] rwt;
    rst = 1'b1;
    bus.opcode = 7'd0; bus.func3 = 3'd0; bus.func7 = 7'd0; bus.br_taken = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.md_done = 1'b0;

    //              op          f3      f7          br ill cyc alu     sa sb rw wb ps
    tbl.push_back('{7'b0010011, 3'b000, 7'b0000000, 0, 0, 4, 4'b0000, 0, 1, 1, 0, 0}); // addi
    tbl.push_back('{7'b0010011, 3'b000, 7'b0100000, 0, 0, 4, 4'b0000, 0, 1, 1, 0, 0}); // addi, imm[10]=1
    tbl.push_back('{7'b0010011, 3'b101, 7'b0100000, 0, 0, 4, 4'b1101, 0, 1, 1, 0, 0}); // srai
    tbl.push_back('{7'b0010011, 3'b101, 7'b0000000, 0, 0, 4, 4'b0101, 0, 1, 1, 0, 0}); // srli
    tbl.push_back('{7'b0110011, 3'b000, 7'b0100000, 0, 0, 4, 4'b1000, 0, 0, 1, 0, 0}); // sub
    tbl.push_back('{7'b0110011, 3'b101, 7'b0100000, 0, 0, 4, 4'b1101, 0, 0, 1, 0, 0}); // sra
    tbl.push_back('{7'b0110011, 3'b011, 7'b0000000, 0, 0, 4, 4'b0011, 0, 0, 1, 0, 0}); // sltu
    tbl.push_back('{7'b0110011, 3'b111, 7'b0000000, 0, 0, 4, 4'b0111, 0, 0, 1, 0, 0}); // and
    tbl.push_back('{7'b1100011, 3'b000, 7'b0000000, 1, 0, 3, 4'b1000, 0, 0, 0, 0, 1}); // beq taken
    tbl.push_back('{7'b1100011, 3'b110, 7'b0000000, 0, 0, 3, 4'b0011, 0, 0, 0, 0, 0}); // bltu not taken
    tbl.push_back('{7'b1100011, 3'b101, 7'b0000000, 1, 0, 3, 4'b0010, 0, 0, 0, 0, 1}); // bge taken
    tbl.push_back('{7'b0000011, 3'b010, 7'b0000000, 0, 0, 5, 4'b0000, 0, 1, 1, 1, 0}); // lw
    tbl.push_back('{7'b0000011, 3'b100, 7'b0000000, 0, 0, 5, 4'b0000, 0, 1, 1, 1, 0}); // lbu
    tbl.push_back('{7'b0100011, 3'b010, 7'b0000000, 0, 0, 4, 4'b0000, 0, 1, 0, 0, 0}); // sw
    tbl.push_back('{7'b0110111, 3'b000, 7'b0000000, 0, 0, 4, 4'b0000, 0, 1, 1, 3, 0}); // lui
    tbl.push_back('{7'b0010111, 3'b000, 7'b0000000, 0, 0, 4, 4'b0000, 1, 1, 1, 0, 0}); // auipc
    tbl.push_back('{7'b1101111, 3'b000, 7'b0000000, 0, 0, 4, 4'b0000, 1, 1, 1, 2, 1}); // jal
    tbl.push_back('{7'b1100111, 3'b000, 7'b0000000, 0, 0, 4, 4'b0000, 0, 1, 1, 2, 2}); // jalr
    tbl.push_back('{7'b0000000, 3'b000, 7'b0000000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // opcode 0
    tbl.push_back('{7'b0110011, 3'b001, 7'b0100000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // bad R func7
    tbl.push_back('{7'b0110011, 3'b000, 7'b0000010, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // bad R func7
    tbl.push_back('{7'b0010011, 3'b001, 7'b0100000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // bad slli
    tbl.push_back('{7'b1100011, 3'b010, 7'b0000000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // bad branch
    tbl.push_back('{7'b0000011, 3'b011, 7'b0000000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // bad load
    tbl.push_back('{7'b0100011, 3'b011, 7'b0000000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // bad store
    tbl.push_back('{7'b0001111, 3'b000, 7'b0000000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // fence
    tbl.push_back('{7'b1110011, 3'b000, 7'b0000000, 0, 1, 3, 4'b0000, 0, 0, 0, 0, 0}); // system

    // Reset state, with imem_ready low so nothing advances
    do_reset();
    #1;
    chk("rst.state", bus.state, 3'd0);
    chk("rst.imem_req", bus.imem_req, 1'b1);
    chk("rst.strobes", {bus.ir_write, bus.dmem_re, bus.dmem_we, bus.reg_write,
                        bus.pc_write, bus.md_start, bus.retire}, 7'd0);
    chk("rst.selects", {bus.pc_sel, bus.alu_src_a, bus.alu_src_b, bus.ALUctl,
                        bus.wb_sel, bus.RW_type}, 14'd0);
    chk("rst.trap", {bus.trap, bus.trap_cause}, 3'd0);
    chk("rst.instret", bus.instret, 4'd0);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // lw with dmem_ready arriving on the 4th MEM cycle
    do_reset();
    bus.opcode = 7'b0000011; bus.func3 = 3'b010; bus.func7 = 7'd0;
    bus.imem_ready = 1'b1;
    cnt = 0; tc = 0; wbs = 2'd0; rwt = 3'd0;
    for (int c = 1; c <= 20; c++) begin
      bus.dmem_ready = (bus.state == 3'd3) && (cnt == 3);
      #1;
      if (bus.dmem_re) cnt++;
      if (bus.state == 3'd3) rwt = bus.RW_type;
      if (bus.reg_write) wbs = bus.wb_sel;
      if (bus.retire) begin tc = c; break; end
      @(negedge clk);
    end
    chk("lw_wait.dmem_re_cycles", cnt, 4);
    chk("lw_wait.retire_cyc", tc, 8);
    chk("lw_wait.wb_sel", wbs, 2'd1);
    chk("lw_wait.RW_type", rwt, 3'b010);
    @(negedge clk); #1;
    chk("lw_wait.instret", bus.instret, 4'd1);

    // imem timeout, then reset recovery
    do_reset();
    for (int c = 1; c <= TMO; c++) begin
      #1;
      if (c == TMO) chk("imem_tmo.last_wait_state", bus.state, 3'd0);
      @(negedge clk);
    end
    #1;
    chk("imem_tmo.state", bus.state, 3'd5);
    chk("imem_tmo.trap", {bus.trap, bus.trap_cause}, {1'b1, 2'd2});
    chk("imem_tmo.imem_req", bus.imem_req, 1'b0);
    do_reset();
    #1;
    chk("imem_tmo.rst_clears", {bus.trap, bus.trap_cause, bus.state}, 6'd0);

    // ready on the final permitted wait cycle wins over the timeout
    do_reset();
    bus.opcode = 7'b0010011; bus.func3 = 3'b000; bus.func7 = 7'd0;
    n = 0;
    for (int c = 1; c <= TMO; c++) begin
      bus.imem_ready = (c == TMO);
      #1;
      if (c < TMO) n += int'(bus.ir_write);
      else chk("late_ready.ir_write", bus.ir_write, 1'b1);
      @(negedge clk);
    end
    #1;
    chk("late_ready.early_ir_write", n, 0);
    chk("late_ready.state", {bus.trap, bus.state}, {1'b0, 3'd1});

    // store with dmem never ready -> dmem timeout
    do_reset();
    bus.opcode = 7'b0100011; bus.func3 = 3'b010; bus.func7 = 7'd0;
    bus.imem_ready = 1'b1;
    cnt = 0; tc = 0;
    for (int c = 1; c <= 25; c++) begin
      #1;
      if (bus.dmem_we) cnt++;
      if (bus.state == 3'd5) begin tc = c; break; end
      @(negedge clk);
    end
    chk("dmem_tmo.trap_cyc", tc, 20);
    chk("dmem_tmo.dmem_we_cycles", cnt, TMO);
    chk("dmem_tmo.cause", {bus.trap, bus.trap_cause}, {1'b1, 2'd3});

    // reset asserted while a store waits in MEM
    do_reset();
    bus.opcode = 7'b0100011; bus.func3 = 3'b000; bus.func7 = 7'd0;
    bus.imem_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c == 5) chk("rst_mem.dmem_we_before", bus.dmem_we, 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mem.dmem_we_after", bus.dmem_we, 1'b0);
    chk("rst_mem.state", bus.state, 3'd0);
    chk("rst_mem.instret", bus.instret, 4'd0);

    // back-to-back addi: instret counts and wraps at 2^CW
    do_reset();
    bus.opcode = 7'b0010011; bus.func3 = 3'b000; bus.func7 = 7'd0;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    n = 0;
    for (int c = 1; c <= 64; c++) begin
      #1;
      n += int'(bus.retire);
      if (c == 9) chk("instret.after_two", bus.instret, 4'd2);
      @(negedge clk);
    end
    #1;
    chk("instret.retires", n, 16);
    chk("instret.wrap", bus.instret, 4'd0);
    for (int c = 1; c <= 4; c++) @(negedge clk);
    #1;
    chk("instret.after_wrap", bus.instret, 4'd1);

    // mul (func7=0000001)
    do_reset();
    bus.opcode = 7'b0110011; bus.func3 = 3'b000; bus.func7 = 7'b0000001;
    bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    n = 0; tc = 0; cnt = 0; wbs = 2'd3;
`ifdef MC_MULDIV_EN
    for (int c = 1; c <= 20; c++) begin
      bus.md_done = (c == 8);
      #1;
      if (bus.md_start) begin n++; cnt = c; end
      if (c == 7) chk("mul.waiting_state", bus.state, 3'd2);
      if (bus.state == 3'd4) begin tc = c; wbs = bus.wb_sel; end
      if (bus.retire) break;
      @(negedge clk);
    end
    chk("mul.md_start_pulses", n, 1);
    chk("mul.md_start_cyc", cnt, 3);
    chk("mul.wb_cyc", tc, 9);
    chk("mul.wb_sel", wbs, 2'd0);
`else
    for (int c = 1; c <= 6; c++) begin
      bus.md_done = 1'b1;
      #1;
      n += int'(bus.md_start);
      if (bus.state == 3'd5) begin tc = c; break; end
      @(negedge clk);
    end
    chk("mul.trap_cyc", tc, 3);
    chk("mul.cause", {bus.trap, bus.trap_cause}, {1'b1, 2'd1});
    chk("mul.md_start", n, 0);
`endif
    bus.md_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
